// File: rtl/preg_free_list_if.sv
// Free-list handshake bundle between rename/retire and the physical register
// free list. The master side (rename + retire) drives requests and releases;
// the slave side (free list) answers with grants, pregs and status.
interface preg_free_list_if #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32
);
    localparam int DEPTH = NUM_PREGS - NUM_AREGS;
    localparam int PW    = $clog2(NUM_PREGS);
    localparam int CW    = $clog2(DEPTH + 1);

    logic [0:1]          alloc_req;
    logic                alloc_gnt;
    logic [0:1][PW-1:0]  alloc_preg;
    logic [0:1]          free_valid;
    logic [0:1][PW-1:0]  free_pregs;
    logic [CW-1:0]       count;
    logic                empty;
    logic                err;

    modport master (
        output alloc_req, free_valid, free_pregs,
        input  alloc_gnt, alloc_preg, count, empty, err
    );

    modport slave (
        input  alloc_req, free_valid, free_pregs,
        output alloc_gnt, alloc_preg, count, empty, err
    );
endinterface

// File: rtl/preg_free_list.sv
// Circular free list of physical registers for the rename stage.
// Hands out up to two pregs per cycle (all-or-nothing) and reclaims up to two
// pregs per cycle from retire. Pointers wrap modulo DEPTH, which need not be a
// power of two. Preg 0 is never reclaimed.
// Optional feature: define PREG_FREELIST_DUPCHK_EN to keep a per-preg free
// vector that rejects double frees (whole release set dropped, err raised).
module preg_free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    preg_free_list_if.slave fl
);
    localparam int DEPTH = NUM_PREGS - NUM_AREGS;
    localparam int PW    = $clog2(NUM_PREGS);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic          err;

    logic [1:0]    nalloc;
    logic [1:0]    nalloc_acc;
    logic [1:0]    nrel;
    logic          gnt;
    logic [0:1]    rel_ok;
    logic [AW-1:0] rd_idx1;
    logic [AW-1:0] wr_idx1;
    logic [AW-1:0] head_next;
    logic [AW-1:0] tail_next;
    logic [CW:0]   occ_post;
    logic          overflow;
    logic          dup;
    logic          rel_accept;

    // Advance a pointer by one, wrapping at DEPTH-1.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Advance a pointer by 0, 1 or 2 positions.
    function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] p, input logic [1:0] n);
        logic [AW-1:0] r;
        r = p;
        if (n != 2'd0) r = ptr_inc(r);
        if (n == 2'd2) r = ptr_inc(r);
        return r;
    endfunction

    // Number of set bits in a two-slot mask.
    function automatic logic [1:0] pop2(input logic [0:1] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    // Grant decision, read addressing and release acceptance for this cycle.
    always_comb begin
        nalloc     = pop2(fl.alloc_req);
        gnt        = ((CW+1)'(nalloc) <= (CW+1)'(count));
        nalloc_acc = gnt ? nalloc : 2'd0;
        // A lone slot-1 request is compacted onto the head entry.
        rd_idx1    = (fl.alloc_req[1] && !fl.alloc_req[0]) ? head : ptr_inc(head);

        rel_ok[0]  = fl.free_valid[0] && (fl.free_pregs[0] != '0);
        rel_ok[1]  = fl.free_valid[1] && (fl.free_pregs[1] != '0);
        nrel       = pop2(rel_ok);
        wr_idx1    = rel_ok[0] ? ptr_inc(tail) : tail;

        // Space is judged after this cycle's allocation has been taken out.
        occ_post   = (CW+1)'(count) - (CW+1)'(nalloc_acc) + (CW+1)'(nrel);
        overflow   = (occ_post > (CW+1)'(DEPTH));
        rel_accept = !overflow && !dup;

        head_next  = ptr_add(head, nalloc_acc);
        tail_next  = ptr_add(tail, rel_accept ? nrel : 2'd0);
    end

    assign fl.alloc_gnt     = gnt;
    assign fl.alloc_preg[0] = mem[head];
    assign fl.alloc_preg[1] = mem[rd_idx1];
    assign fl.count         = count;
    assign fl.empty         = (count == '0);
    assign fl.err           = err;

    // Pointer, occupancy and sticky error state; reset wins over any request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head  <= '0;
            tail  <= '0;
            count <= CW'(DEPTH);
            err   <= 1'b0;
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= rel_accept ? occ_post[CW-1:0] : (count - CW'(nalloc_acc));
            err   <= err | overflow | dup;
        end
    end

    // FIFO storage: preloaded with the unmapped pregs, written compactly at tail.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PW'(NUM_AREGS + i);
            end
        end else if (rel_accept) begin
            if (rel_ok[0]) mem[tail]    <= fl.free_pregs[0];
            if (rel_ok[1]) mem[wr_idx1] <= fl.free_pregs[1];
        end
    end

`ifdef PREG_FREELIST_DUPCHK_EN
    logic [NUM_PREGS-1:0] free_vec;

    // A release is a duplicate if the preg is already free or both slots name it.
    always_comb begin
        dup = 1'b0;
        if (rel_ok[0] && free_vec[fl.free_pregs[0]]) dup = 1'b1;
        if (rel_ok[1] && free_vec[fl.free_pregs[1]]) dup = 1'b1;
        if (rel_ok[0] && rel_ok[1] && (fl.free_pregs[0] == fl.free_pregs[1])) dup = 1'b1;
    end

    // Track which pregs currently sit in the free list.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                free_vec[i] <= (i >= NUM_AREGS);
            end
        end else begin
            if (gnt && fl.alloc_req[0]) free_vec[fl.alloc_preg[0]] <= 1'b0;
            if (gnt && fl.alloc_req[1]) free_vec[fl.alloc_preg[1]] <= 1'b0;
            if (rel_accept && rel_ok[0]) free_vec[fl.free_pregs[0]] <= 1'b1;
            if (rel_accept && rel_ok[1]) free_vec[fl.free_pregs[1]] <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif
endmodule

// File: tb/tb_preg_free_list.sv
// Bench for preg_free_list: directed table, hand-written corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_preg_free_list;
    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 32;
    localparam int DEPTH     = NUM_PREGS - NUM_AREGS;

    logic i_clk = 1'b0;
    logic i_rst;

    always #5 i_clk = ~i_clk;

    preg_free_list_if #(.NUM_PREGS(NUM_PREGS), .NUM_AREGS(NUM_AREGS)) fl();

    preg_free_list #(.NUM_PREGS(NUM_PREGS), .NUM_AREGS(NUM_AREGS)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .fl    (fl)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        bit    r0, r1, v0, v1;
        int    p0, p1;
        bit    g;
        bit    c0; int a0;
        bit    c1; int a1;
        int    cnt;
        bit    e;
    } vec_t;

    vec_t vt[$];

    // Reference model state: the free list as an ordered queue of pregs.
    int q[$];
    bit merr;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit r0, input bit r1,
                         input bit v0, input bit v1, input int p0, input int p1);
        i_rst            = rst;
        fl.alloc_req[0]  = r0;
        fl.alloc_req[1]  = r1;
        fl.free_valid[0] = v0;
        fl.free_valid[1] = v1;
        fl.free_pregs[0] = 6'(p0);
        fl.free_pregs[1] = 6'(p1);
        #1;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_regs(input string n, input int cnt, input int e);
        check({n, "_count"}, int'(fl.count), cnt);
        check({n, "_empty"}, int'(fl.empty), (cnt == 0) ? 1 : 0);
        check({n, "_err"}, int'(fl.err), e);
    endtask

    function automatic vec_t mkv(string n, bit r0, bit r1, bit v0, bit v1, int p0, int p1,
                                 bit g, bit c0, int a0, bit c1, int a1, int cnt, bit e);
        vec_t v;
        v.name = n; v.r0 = r0; v.r1 = r1; v.v0 = v0; v.v1 = v1; v.p0 = p0; v.p1 = p1;
        v.g = g; v.c0 = c0; v.a0 = a0; v.c1 = c1; v.a1 = a1; v.cnt = cnt; v.e = e;
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back(NUM_AREGS + i);
        merr = 1'b0;
    endtask

    function automatic bit in_list(int p);
        foreach (q[i]) if (q[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    // One randomized cycle: compare combinational grant/pregs, clock, then state.
    task automatic rand_cycle(input int n);
        bit rst, r0, r1, v0, v1, g, drop;
        int p0, p1, na, post;
        int rel[$];
        rst = ($urandom_range(0, 199) == 0);
        r0  = $urandom_range(0, 1); r1 = $urandom_range(0, 1);
        v0  = ($urandom_range(0, 2) == 0); v1 = ($urandom_range(0, 2) == 0);
        p0  = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, NUM_PREGS - 1);
        p1  = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, NUM_PREGS - 1);
        drive(rst, r0, r1, v0, v1, p0, p1);
        na = int'(r0) + int'(r1);
        g  = (na <= q.size());
        if (!rst) begin
            check($sformatf("rnd%0d_gnt", n), int'(fl.alloc_gnt), int'(g));
            if (g && r0) check($sformatf("rnd%0d_a0", n), int'(fl.alloc_preg[0]), q[0]);
            if (g && r1) check($sformatf("rnd%0d_a1", n), int'(fl.alloc_preg[1]), r0 ? q[1] : q[0]);
        end
        tick();
        if (rst) begin
            model_reset();
        end else begin
            if (v0 && p0 != 0) rel.push_back(p0);
            if (v1 && p1 != 0) rel.push_back(p1);
            post = q.size() - (g ? na : 0) + rel.size();
            drop = (post > DEPTH);
`ifdef PREG_FREELIST_DUPCHK_EN
            foreach (rel[i]) if (in_list(rel[i])) drop = 1'b1;
            if (rel.size() == 2 && rel[0] == rel[1]) drop = 1'b1;
`endif
            if (drop) merr = 1'b1;
            if (g) for (int i = 0; i < na; i++) void'(q.pop_front());
            if (!drop) foreach (rel[i]) q.push_back(rel[i]);
        end
        check_regs($sformatf("rnd%0d", n), q.size(), int'(merr));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check_regs("reset", DEPTH, 0);

        // Directed table: drain the list, refill two, reissue them, ignore preg 0.
        for (int i = 0; i < 16; i++)
            vt.push_back(mkv($sformatf("drain%0d", i), 1, 1, 0, 0, 0, 0,
                             1, 1, 32 + 2 * i, 1, 33 + 2 * i, 30 - 2 * i, 0));
        vt.push_back(mkv("empty_req", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mkv("refill", 0, 0, 1, 1, 40, 7, 1, 0, 0, 0, 0, 2, 0));
        vt.push_back(mkv("reissue", 1, 1, 0, 0, 0, 0, 1, 1, 40, 1, 7, 0, 0));
        vt.push_back(mkv("free_p0", 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        drive(0, 0, 0, 0, 0, 0, 0);
        foreach (vt[i]) begin
            drive(0, vt[i].r0, vt[i].r1, vt[i].v0, vt[i].v1, vt[i].p0, vt[i].p1);
            check({vt[i].name, "_gnt"}, int'(fl.alloc_gnt), int'(vt[i].g));
            if (vt[i].c0) check({vt[i].name, "_a0"}, int'(fl.alloc_preg[0]), vt[i].a0);
            if (vt[i].c1) check({vt[i].name, "_a1"}, int'(fl.alloc_preg[1]), vt[i].a1);
            tick();
            check_regs(vt[i].name, vt[i].cnt, int'(vt[i].e));
        end

        // No partial grant, and a same-cycle release is not bypassed.
        drive(0, 0, 0, 1, 0, 5, 0);
        tick();
        check_regs("one_left", 1, 0);
        drive(0, 1, 1, 1, 0, 9, 0);
        check("nopartial_gnt", int'(fl.alloc_gnt), 0);
        tick();
        check_regs("nopartial", 2, 0);
        drive(0, 1, 1, 0, 0, 0, 0);
        check("after_gnt", int'(fl.alloc_gnt), 1);
        check("after_a0", int'(fl.alloc_preg[0]), 5);
        check("after_a1", int'(fl.alloc_preg[1]), 9);
        tick();
        check_regs("after", 0, 0);

        // Lone slot-1 request is compacted onto the head entry.
        drive(0, 0, 0, 1, 0, 11, 0);
        tick();
        drive(0, 0, 1, 0, 0, 0, 0);
        check("lone1_gnt", int'(fl.alloc_gnt), 1);
        check("lone1_a1", int'(fl.alloc_preg[1]), 11);
        tick();
        check_regs("lone1", 0, 0);

        // Overflow at full occupancy drops the release and sets a sticky error.
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        check_regs("reset2", DEPTH, 0);
        drive(0, 0, 0, 0, 1, 0, 12);
        tick();
        check_regs("overflow", DEPTH, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        check_regs("sticky", DEPTH, 1);

        // Reset in the middle of allocation discards the grant.
        drive(0, 1, 1, 0, 0, 0, 0);
        tick();
        drive(1, 1, 1, 1, 1, 3, 4);
        tick();
        check_regs("midreset", DEPTH, 0);
        drive(0, 1, 1, 0, 0, 0, 0);
        check("postreset_a0", int'(fl.alloc_preg[0]), 32);
        check("postreset_a1", int'(fl.alloc_preg[1]), 33);
        tick();
        check_regs("postreset", 30, 0);

        // Freeing the same preg twice in consecutive cycles.
        drive(0, 0, 0, 1, 0, 32, 0);
        tick();
        check_regs("dfree1", 31, 0);
        drive(0, 0, 0, 1, 0, 32, 0);
        tick();
`ifdef PREG_FREELIST_DUPCHK_EN
        check_regs("dfree2", 31, 1);
`else
        check_regs("dfree2", 32, 0);
`endif

        // Randomized traffic against the reference model.
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        model_reset();
        check_regs("rnd_reset", q.size(), 0);
        for (int n = 0; n < 3000; n++) rand_cycle(n);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
